instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/instr_sequencer_if.sv | 33 +++
 rtl/instr_decode.sv | 50 +++++
 rtl/instr_sequencer.sv | 106 ++++++++++
 tb/tb_instr_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: FSM states, opcode/func constants and ALU select codes.
// Used by the sequencer, its decoder, the control unit and the ALU.
package cpu_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [3:0] {
    AluNop = 4'b0000,
    AluAdd = 4'b0001,
    AluSub = 4'b0010,
    AluOr  = 4'b0011,
    AluAnd = 4'b0100,
    AluXor = 4'b0101
  } alu_op_e;

  localparam logic [6:0] OpcRType = 7'b0110011;
  localparam logic [6:0] OpcLoad  = 7'b0000011;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Sub  = 7'b0100000;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  localparam logic [31:0] PcStep = 32'd4;

endpackage

// File: rtl/instr_sequencer_if.sv
// Fetch/load handshake and decoded-instruction bus of the instruction sequencer.
// master = sequencer side, slave = memory/datapath side.
interface instr_sequencer_if;

  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        dmem_req;
  logic        dmem_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic        reg_wen;
  logic        reg_flag;
  logic        instr_done;
  logic        illegal;

  modport master (
    output imem_req, pc, dmem_req, rs1, rs2, rd, imm, alu_op,
           reg_wen, reg_flag, instr_done, illegal,
    input  imem_ready, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, pc, dmem_req, rs1, rs2, rd, imm, alu_op,
           reg_wen, reg_flag, instr_done, illegal,
    output imem_ready, imem_rdata, dmem_ready
  );

endinterface

// File: rtl/instr_decode.sv
// Combinational decoder: classifies an instruction word as legal R-type/load
// and selects the ALU operation.
module instr_decode
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH_OP = 7
) (
  input  logic [31:0] instr_i,
  output logic        legal_o,
  output logic        is_load_o,
  output alu_op_e     alu_op_o
);

  logic [WIDTH_OP-1:0] opcode;
  logic [WIDTH_OP-1:0] func7;
  logic [2:0]          func3;
  logic                unused_fields;

  assign opcode = instr_i[WIDTH_OP-1:0];
  assign func7  = instr_i[31 -: WIDTH_OP];
  assign func3  = instr_i[14:12];

  // Register fields are consumed by the sequencer, not here.
  assign unused_fields = ^{instr_i[24:15], instr_i[11:WIDTH_OP]};

  always_comb begin
    legal_o   = 1'b0;
    is_load_o = 1'b0;
    alu_op_o  = AluNop;
    if (opcode == OpcLoad) begin
      legal_o   = 1'b1;
      is_load_o = 1'b1;
      alu_op_o  = AluAdd;
    end else if (opcode == OpcRType) begin
      if (func7 == F7Base) begin
        unique case (func3)
          F3AddSub: begin legal_o = 1'b1; alu_op_o = AluAdd; end
          F3Xor:    begin legal_o = 1'b1; alu_op_o = AluXor; end
          F3Or:     begin legal_o = 1'b1; alu_op_o = AluOr;  end
          F3And:    begin legal_o = 1'b1; alu_op_o = AluAnd; end
          default:  ;
        endcase
      end else if (func7 == F7Sub && func3 == F3AddSub) begin
        legal_o  = 1'b1;
        alu_op_o = AluSub;
      end
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with PC and
// fetch/load handshakes; unsupported instructions halt until reset.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH_OP = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  instr_sequencer_if.master  bus_io
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  alu_op_e     alu_op_q, alu_op_d;
  logic        is_load_q, is_load_d;
  logic        illegal_q, illegal_d;

  logic        dec_legal;
  logic        dec_is_load;
  alu_op_e     dec_alu_op;

  instr_decode #(
    .WIDTH_OP (WIDTH_OP)
  ) u_instr_decode (
    .instr_i   (instr_q),
    .legal_o   (dec_legal),
    .is_load_o (dec_is_load),
    .alu_op_o  (dec_alu_op)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    alu_op_d  = alu_op_q;
    is_load_d = is_load_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StFetch: begin
        if (bus_io.imem_ready) begin
          instr_d = bus_io.imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        alu_op_d  = dec_alu_op;
        is_load_d = dec_is_load;
        if (dec_legal) begin
          state_d = StExecute;
        end else begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end
      end
      StExecute: state_d = is_load_q ? StMem : StWb;
      StMem: begin
        if (bus_io.dmem_ready) begin
          state_d = StWb;
        end
      end
      StWb: begin
        pc_d    = pc_q + PcStep;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      alu_op_q  <= AluNop;
      is_load_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      alu_op_q  <= alu_op_d;
      is_load_q <= is_load_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes are masked while rst is high so a reset abandons requests at once.
  assign bus_io.imem_req   = (state_q == StFetch) && !rst;
  assign bus_io.dmem_req   = (state_q == StMem) && !rst;
  assign bus_io.reg_wen    = (state_q == StWb) && !rst && (instr_q[11:7] != 5'd0);
  assign bus_io.instr_done = (state_q == StWb) && !rst;
  assign bus_io.reg_flag   = (state_q == StWb) && is_load_q;
  assign bus_io.illegal    = illegal_q;
  assign bus_io.alu_op     = alu_op_q;
  assign bus_io.pc         = pc_q;

  assign bus_io.rs1 = instr_q[19:15];
  assign bus_io.rs2 = instr_q[24:20];
  assign bus_io.rd  = instr_q[11:7];
  assign bus_io.imm = {{20{instr_q[31]}}, instr_q[31:20]};

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset, R-type/load flows, wait states,
// illegal halt, reset during MEM and PC wrap-around.
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  instr_sequencer_if bus ();
  instr_sequencer_if bus_w ();

  instr_sequencer #(
    .WIDTH_OP (7),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  instr_sequencer #(
    .WIDTH_OP (7),
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_w (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_w)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] InstrAdd   = 32'h002081B3;
  localparam logic [31:0] InstrSub   = 32'h402081B3;
  localparam logic [31:0] InstrLw    = 32'hFFC0A283;
  localparam logic [31:0] InstrBeq   = 32'h00208463;
  localparam logic [31:0] InstrAddX0 = 32'h00208033;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.imem_ready = 1'b0;   bus.dmem_ready = 1'b0;   bus.imem_rdata = '0;
    bus_w.imem_ready = 1'b0; bus_w.dmem_ready = 1'b0; bus_w.imem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if (bus.pc !== 32'h0) begin
      err_cnt++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0);
    end
    vec_cnt++;
    if ({bus.alu_op, bus.reg_wen, bus.reg_flag, bus.instr_done, bus.dmem_req, bus.illegal}
        !== 9'b0) begin
      err_cnt++;
      $display("FAIL reset_strobes: got alu=%b wen=%b flag=%b done=%b dreq=%b ill=%b want 0",
               bus.alu_op, bus.reg_wen, bus.reg_flag, bus.instr_done, bus.dmem_req,
               bus.illegal);
    end
    vec_cnt++;
    if ({bus.rd, bus.imm} !== 37'h0) begin
      err_cnt++; $display("FAIL reset_ir: got rd=%0d imm=%h want 0", bus.rd, bus.imm);
    end
    vec_cnt++;
    if (bus_w.pc !== 32'hFFFF_FFFC) begin
      err_cnt++; $display("FAIL reset_pc_param: got %h want %h", bus_w.pc, 32'hFFFF_FFFC);
    end
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (bus.imem_req !== 1'b1) begin
      err_cnt++; $display("FAIL reset_imem_req: got %b want 1", bus.imem_req);
    end
  endtask

  task automatic test_add();
    apply_reset();
    bus.imem_rdata = InstrAdd;
    bus.imem_ready = 1'b1;
    vec_cnt++;
    if (bus.imem_req !== 1'b1) begin
      err_cnt++; $display("FAIL add_fetch_req: got %b want 1", bus.imem_req);
    end
    tick();
    bus.imem_ready = 1'b0;
    vec_cnt++;
    if ({bus.rs1, bus.rs2, bus.rd, bus.imem_req} !== {5'd1, 5'd2, 5'd3, 1'b0}) begin
      err_cnt++;
      $display("FAIL add_decode_fields: got rs1=%0d rs2=%0d rd=%0d ireq=%b want 1 2 3 0",
               bus.rs1, bus.rs2, bus.rd, bus.imem_req);
    end
    tick();
    vec_cnt++;
    if ({bus.alu_op, bus.reg_wen} !== {4'b0001, 1'b0}) begin
      err_cnt++;
      $display("FAIL add_execute: got alu=%b wen=%b want 0001 0", bus.alu_op, bus.reg_wen);
    end
    tick();
    vec_cnt++;
    if ({bus.reg_wen, bus.reg_flag, bus.instr_done, bus.pc} !== {3'b101, 32'h0}) begin
      err_cnt++;
      $display("FAIL add_wb: got wen=%b flag=%b done=%b pc=%h want 1 0 1 0",
               bus.reg_wen, bus.reg_flag, bus.instr_done, bus.pc);
    end
    tick();
    vec_cnt++;
    if ({bus.pc, bus.imem_req, bus.reg_wen, bus.instr_done} !== {32'h4, 3'b100}) begin
      err_cnt++;
      $display("FAIL add_next_fetch: got pc=%h ireq=%b wen=%b done=%b want 4 1 0 0",
               bus.pc, bus.imem_req, bus.reg_wen, bus.instr_done);
    end
  endtask

  task automatic test_sub_wait();
    int req_cyc = 0;
    int done_cyc = 0;
    int overlap = 0;
    logic [3:0] alu = 4'hF;
    apply_reset();
    bus.imem_rdata = InstrSub;
    for (int c = 1; c <= 15; c++) begin
      bus.imem_ready = (c == 4);
      if (done_cyc == 0 && bus.imem_req) req_cyc++;
      if (bus.imem_req && bus.dmem_req) overlap++;
      if (bus.instr_done && done_cyc == 0) begin
        done_cyc = c;
        alu = bus.alu_op;
      end
      tick();
    end
    bus.imem_ready = 1'b0;
    vec_cnt++;
    if (req_cyc !== 4) begin
      err_cnt++; $display("FAIL sub_imem_req_cycles: got %0d want 4", req_cyc);
    end
    vec_cnt++;
    if (done_cyc !== 7) begin
      err_cnt++; $display("FAIL sub_done_cycle: got %0d want 7", done_cyc);
    end
    vec_cnt++;
    if (alu !== 4'b0010) begin
      err_cnt++; $display("FAIL sub_alu_op: got %b want 0010", alu);
    end
    vec_cnt++;
    if (overlap !== 0) begin
      err_cnt++; $display("FAIL sub_req_overlap: got %0d want 0", overlap);
    end
  endtask

  task automatic test_load_wait();
    int dreq_cyc = 0;
    int wen_cnt = 0;
    int overlap = 0;
    logic flag = 1'b0;
    logic [31:0] imm = '0;
    logic [4:0]  rd = '0;
    apply_reset();
    bus.imem_rdata = InstrLw;
    for (int c = 1; c <= 12; c++) begin
      bus.imem_ready = (c == 1);
      bus.dmem_ready = (c == 6);
      if (c == 2) begin
        imm = bus.imm;
        rd  = bus.rd;
      end
      if (bus.dmem_req) dreq_cyc++;
      if (bus.imem_req && bus.dmem_req) overlap++;
      if (bus.reg_wen) begin
        wen_cnt++;
        flag = bus.reg_flag;
      end
      tick();
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    vec_cnt++;
    if ({imm, rd} !== {32'hFFFF_FFFC, 5'd5}) begin
      err_cnt++; $display("FAIL lw_imm_rd: got imm=%h rd=%0d want fffffffc 5", imm, rd);
    end
    vec_cnt++;
    if (dreq_cyc !== 3) begin
      err_cnt++; $display("FAIL lw_dmem_req_cycles: got %0d want 3", dreq_cyc);
    end
    vec_cnt++;
    if ({wen_cnt, flag} !== {32'd1, 1'b1}) begin
      err_cnt++; $display("FAIL lw_writeback: got wen_cnt=%0d flag=%b want 1 1", wen_cnt, flag);
    end
    vec_cnt++;
    if ({bus.pc, overlap} !== {32'h4, 32'd0}) begin
      err_cnt++; $display("FAIL lw_pc_overlap: got pc=%h overlap=%0d want 4 0", bus.pc, overlap);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [4] = '{32'h0020C1B3, 32'h0020E1B3, 32'h0020F1B3, InstrSub};
    logic [3:0]  expa [4] = '{4'b0101, 4'b0011, 4'b0100, 4'b0010};
    apply_reset();
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.imem_rdata = prog[i];
      vec_cnt++;
      if (bus.imem_req !== 1'b1) begin
        err_cnt++; $display("FAIL b2b_fetch[%0d]: got ireq=%b want 1", i, bus.imem_req);
      end
      tick();
      tick();
      vec_cnt++;
      if (bus.alu_op !== expa[i]) begin
        err_cnt++; $display("FAIL b2b_alu[%0d]: got %b want %b", i, bus.alu_op, expa[i]);
      end
      tick();
      vec_cnt++;
      if (bus.instr_done !== 1'b1) begin
        err_cnt++; $display("FAIL b2b_done[%0d]: got %b want 1", i, bus.instr_done);
      end
      tick();
    end
    bus.imem_ready = 1'b0;
    vec_cnt++;
    if (bus.pc !== 32'h10) begin
      err_cnt++; $display("FAIL b2b_pc: got %h want %h", bus.pc, 32'h10);
    end
  endtask

  task automatic test_illegal();
    int bad = 0;
    apply_reset();
    bus.imem_rdata = InstrAdd;
    bus.imem_ready = 1'b1;
    repeat (4) tick();
    bus.imem_rdata = InstrBeq;
    tick();
    vec_cnt++;
    if (bus.illegal !== 1'b0) begin
      err_cnt++; $display("FAIL ill_before_decode: got %b want 0", bus.illegal);
    end
    tick();
    vec_cnt++;
    if (bus.illegal !== 1'b1) begin
      err_cnt++; $display("FAIL ill_set: got %b want 1", bus.illegal);
    end
    bus.dmem_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.reg_wen || bus.imem_req || bus.dmem_req || bus.instr_done ||
          bus.pc !== 32'h4 || bus.illegal !== 1'b1) bad++;
      tick();
    end
    vec_cnt++;
    if (bad !== 0) begin
      err_cnt++; $display("FAIL ill_halt_hold: got %0d bad cycles want 0", bad);
    end
    apply_reset();
    vec_cnt++;
    if ({bus.illegal, bus.pc, bus.imem_req} !== {1'b0, 32'h0, 1'b1}) begin
      err_cnt++;
      $display("FAIL ill_reset_clear: got ill=%b pc=%h ireq=%b want 0 0 1",
               bus.illegal, bus.pc, bus.imem_req);
    end
    // func7=0100000 is only legal with func3=000.
    bus.imem_rdata = 32'h4020C1B3;
    bus.imem_ready = 1'b1;
    tick();
    tick();
    bus.imem_ready = 1'b0;
    vec_cnt++;
    if ({bus.illegal, bus.imem_req} !== 2'b10) begin
      err_cnt++;
      $display("FAIL ill_sub_xor: got ill=%b ireq=%b want 1 0", bus.illegal, bus.imem_req);
    end
  endtask

  task automatic test_rst_mem();
    int wb = 0;
    apply_reset();
    bus.imem_rdata = InstrAdd;
    bus.imem_ready = 1'b1;
    repeat (4) tick();
    bus.imem_rdata = InstrLw;
    tick();
    bus.imem_ready = 1'b0;
    tick();
    tick();
    vec_cnt++;
    if ({bus.dmem_req, bus.pc} !== {1'b1, 32'h4}) begin
      err_cnt++; $display("FAIL rstmem_in_mem: got dreq=%b pc=%h want 1 4", bus.dmem_req, bus.pc);
    end
    rst = 1'b1;
    bus.dmem_ready = 1'b1;
    tick();
    vec_cnt++;
    if ({bus.dmem_req, bus.reg_wen, bus.instr_done, bus.pc} !== {3'b000, 32'h0}) begin
      err_cnt++;
      $display("FAIL rstmem_abandon: got dreq=%b wen=%b done=%b pc=%h want 0 0 0 0",
               bus.dmem_req, bus.reg_wen, bus.instr_done, bus.pc);
    end
    rst = 1'b0;
    bus.dmem_ready = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.imem_req, bus.dmem_req} !== 2'b10) begin
      err_cnt++;
      $display("FAIL rstmem_fetch: got ireq=%b dreq=%b want 1 0", bus.imem_req, bus.dmem_req);
    end
    for (int c = 0; c < 5; c++) begin
      if (bus.reg_wen || bus.instr_done) wb++;
      tick();
    end
    vec_cnt++;
    if (wb !== 0) begin
      err_cnt++; $display("FAIL rstmem_no_wb: got %0d writebacks want 0", wb);
    end
  endtask

  task automatic test_wrap();
    int wen = 0;
    int done = 0;
    apply_reset();
    bus_w.imem_rdata = InstrAdd;
    bus_w.imem_ready = 1'b1;
    tick();
    bus_w.imem_ready = 1'b0;
    tick();
    tick();
    vec_cnt++;
    if ({bus_w.instr_done, bus_w.pc} !== {1'b1, 32'hFFFF_FFFC}) begin
      err_cnt++;
      $display("FAIL wrap_wb: got done=%b pc=%h want 1 fffffffc", bus_w.instr_done, bus_w.pc);
    end
    tick();
    vec_cnt++;
    if (bus_w.pc !== 32'h0) begin
      err_cnt++; $display("FAIL wrap_pc: got %h want %h", bus_w.pc, 32'h0);
    end
    bus_w.imem_rdata = InstrAddX0;
    bus_w.imem_ready = 1'b1;
    tick();
    bus_w.imem_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus_w.reg_wen) wen++;
      if (bus_w.instr_done) done++;
      tick();
    end
    vec_cnt++;
    if ({wen, done} !== {32'd0, 32'd1}) begin
      err_cnt++; $display("FAIL rd0_wen: got wen=%0d done=%0d want 0 1", wen, done);
    end
    vec_cnt++;
    if (bus_w.pc !== 32'h4) begin
      err_cnt++; $display("FAIL rd0_pc: got %h want %h", bus_w.pc, 32'h4);
    end
  endtask

  initial begin
    bus.imem_ready = 1'b0;   bus.dmem_ready = 1'b0;   bus.imem_rdata = '0;
    bus_w.imem_ready = 1'b0; bus_w.dmem_ready = 1'b0; bus_w.imem_rdata = '0;
    test_reset();
    test_add();
    test_sub_wait();
    test_load_wait();
    test_back_to_back();
    test_illegal();
    test_rst_mem();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
